// File: rtl/cache_fill_ctrl.sv
// I/D miss arbiter and 8-word block fill sequencer for the shared memory read port.
// Owns the port from grant until the tag write; in-order pipelined beats.
module cache_fill_ctrl #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  output logic        mem_enable,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_data_write,
  output logic        d_data_write,
  output logic        i_tag_write,
  output logic        d_tag_write,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        busy
);

  if (MEM_LATENCY < 1) begin : g_bad_lat
    $error("MEM_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_TAG,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_side;
  logic        r_last;
  logic [15:0] r_base;
  logic [3:0]  r_issue;
  logic [2:0]  r_recv;
  logic        r_mem_en;
  logic [15:0] r_mem_addr;
  logic        r_tag_wr;
  logic        r_done;

  logic        w_req;
  logic        w_side;
  logic [15:0] w_base;
  logic        w_beat;

  // side: 0 = I, 1 = D; a tie goes to whoever was not served last
  assign w_req  = i_miss | d_miss;
  assign w_side = (i_miss & d_miss) ? ~r_last : d_miss;
  assign w_base = w_side ? (d_miss_addr & 16'hFFF0)
                         : (i_miss_addr & 16'hFFF0);
  assign w_beat = (r_state == S_FILL) & mem_data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_side     <= 1'b0;
      r_last     <= 1'b0;
      r_base     <= 16'h0;
      r_issue    <= 4'd0;
      r_recv     <= 3'd0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= 16'h0;
      r_tag_wr   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_side     <= w_side;
            r_base     <= w_base;
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_base;
            r_issue    <= 4'd1;
            r_recv     <= 3'd0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (r_issue[3]) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= 16'h0;
          end else begin
            r_mem_addr <= r_base | {12'h0, r_issue[2:0], 1'b0};
            r_issue    <= r_issue + 4'd1;
          end
          if (mem_data_valid) begin
            r_recv <= r_recv + 3'd1;
            if (r_recv == 3'd7) begin
              r_state  <= S_TAG;
              r_tag_wr <= 1'b1;
            end
          end
        end
        S_TAG: begin
          r_mem_en   <= 1'b0;
          r_mem_addr <= 16'h0;
          r_tag_wr   <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_last  <= r_side;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_enable   = r_mem_en;
  assign mem_addr     = r_mem_addr;
  assign fill_data    = w_beat ? mem_data_in : 16'h0;
  assign fill_addr    = w_beat ? (r_base | {12'h0, r_recv, 1'b0})
                      : (r_state == S_TAG) ? r_base : 16'h0;
  assign i_data_write = w_beat & ~r_side;
  assign d_data_write = w_beat & r_side;
  assign i_tag_write  = r_tag_wr & ~r_side;
  assign d_tag_write  = r_tag_wr & r_side;
  assign i_fill_done  = r_done & ~r_side;
  assign d_fill_done  = r_done & r_side;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: pipelined memory model plus a schedule-based
// reference that predicts every output cycle by cycle from the grant cycle.
module tb_cache_fill_ctrl;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0;
  logic        d_miss = 1'b0;
  logic [15:0] i_miss_addr = 16'h0;
  logic [15:0] d_miss_addr = 16'h0;
  logic        mem_enable;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        i_data_write, d_data_write;
  logic        i_tag_write, d_tag_write;
  logic        i_fill_done, d_fill_done;
  logic        busy;

  logic        inj = 1'b0;
  logic [15:0] inj_data = 16'h0;
  logic [15:0] salt = 16'h5A3C;
  logic        pv [L];
  logic [15:0] pa [L];

  int n_checks = 0;
  int n_fail = 0;
  bit tb_last = 1'b0;

  cache_fill_ctrl #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_enable(mem_enable), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_data_write(i_data_write), .d_data_write(d_data_write),
    .i_tag_write(i_tag_write), .d_tag_write(d_tag_write),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mf(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  initial begin
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0;
    end
  end

  // memory: a request issued in cycle c returns in cycle c+L
  always @(posedge clk) begin
    pv[0] <= mem_enable;
    pa[0] <= mem_addr;
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign mem_data_valid = inj | pv[L-1];
  assign mem_data_in = inj ? inj_data
                     : (pv[L-1] ? mf(pa[L-1]) : 16'h0);

  function automatic logic [55:0] obs();
    return {mem_enable, mem_addr, fill_addr, fill_data,
            i_data_write, d_data_write, i_tag_write, d_tag_write,
            i_fill_done, d_fill_done, busy};
  endfunction

  // expected outputs t cycles after the grant cycle (s: 0=I, 1=D)
  function automatic logic [55:0] exp_at(input bit s,
                                         input logic [15:0] b,
                                         input int t);
    logic en, dw, tw, fdn, bz;
    logic [15:0] ma, fa, fd;
    int k;
    en = 0; dw = 0; tw = 0; fdn = 0;
    ma = 0; fa = 0; fd = 0;
    if (t >= 1 && t <= 8) begin
      en = 1;
      ma = b + 16'((t - 1) * 2);
    end
    k = t - 1 - L;
    if (k >= 0 && k < 8) begin
      dw = 1;
      fa = b + 16'(k * 2);
      fd = mf(fa);
    end
    if (t == 9 + L) begin
      tw = 1;
      fa = b;
    end
    if (t == 10 + L) fdn = 1;
    bz = (t >= 1 && t <= 10 + L);
    return {en, ma, fa, fd, dw & ~s, dw & s, tw & ~s, tw & s,
            fdn & ~s, fdn & s, bz};
  endfunction

  function automatic bit pick(input bit i, input bit d);
    if (i && d) return ~tb_last;
    return d;
  endfunction

  // caller sits at the negedge of the grant cycle (t = 0)
  task automatic run_fill(input bit s, input logic [15:0] addr,
                          input int inj_from, input int drop_t,
                          input int last_t);
    logic [15:0] b;
    logic [55:0] e, o;
    b = addr & 16'hFFF0;
    for (int t = 1; t <= last_t; t++) begin
      @(posedge clk);
      #1;
      inj = (inj_from > 0) && (t >= inj_from);
      inj_data = 16'($urandom);
      if (t == drop_t) begin
        if (s) d_miss = 1'b0;
        else i_miss = 1'b0;
      end
      @(negedge clk);
      e = exp_at(s, b, t);
      o = obs();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fill side=%0d base=%h t=%0d got=%h want=%h",
                 s, b, t, o, e);
      end
    end
    inj = 1'b0;
    if (last_t == 10 + L) tb_last = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (obs() !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", obs());
    end
    rst = 1'b0;
    tb_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== 56'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%h want=0", obs());
    end
  endtask

  task automatic test_i_only();
    i_miss_addr = 16'h1236;
    i_miss = 1'b1;
    run_fill(1'b0, 16'h1236, 0, 0, 10 + L);
    i_miss = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== 56'h0) begin
      n_fail++;
      $display("FAIL i_only_idle got=%h want=0", obs());
    end
  endtask

  task automatic test_tie();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b0;
    i_miss_addr = 16'($urandom);
    d_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    d_miss = 1'b1;
    run_fill(pick(1, 1), d_miss_addr, 0, 0, 10 + L);
    d_miss = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs() !== 56'h0) begin
      n_fail++;
      $display("FAIL tie_gap got=%h want=0", obs());
    end
    run_fill(pick(1, 0), i_miss_addr, 0, 0, 10 + L);
    i_miss = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    bit s;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b0;
    i_miss_addr = 16'($urandom);
    d_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    d_miss = 1'b1;
    for (int f = 0; f < 4; f++) begin
      s = pick(1, 1);
      run_fill(s, s ? d_miss_addr : i_miss_addr, 0, 0, 10 + L);
      if (s) d_miss_addr = 16'($urandom);
      else i_miss_addr = 16'($urandom);
      if (f == 3) begin
        i_miss = 1'b0;
        d_miss = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL alt_gap f=%0d busy=%b want=0", f, busy);
      end
    end
  endtask

  task automatic test_rst_mid();
    i_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    run_fill(1'b0, i_miss_addr, 0, 0, 7);
    rst = 1'b1;
    for (int c = 8; c <= 11; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== 56'h0) begin
        n_fail++;
        $display("FAIL rst_mid c=%0d got=%h want=0", c, obs());
      end
    end
    rst = 1'b0;
    tb_last = 1'b0;
    run_fill(1'b0, i_miss_addr, 0, 0, 10 + L);
    i_miss = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      inj = 1'b1;
      inj_data = 16'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs() !== 56'h0) begin
        n_fail++;
        $display("FAIL stray_idle c=%0d got=%h want=0", c, obs());
      end
    end
    inj = 1'b0;
    @(negedge clk);
    d_miss_addr = 16'($urandom);
    d_miss = 1'b1;
    run_fill(1'b1, d_miss_addr, 9 + L, 0, 10 + L);
    d_miss = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    d_miss_addr = 16'hFFFE;
    d_miss = 1'b1;
    run_fill(1'b1, 16'hFFFE, 0, 0, 10 + L);
    d_miss = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop();
    i_miss_addr = 16'($urandom);
    i_miss = 1'b1;
    run_fill(1'b0, i_miss_addr, 0, 3, 10 + L);
    i_miss = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int r;
    bit s;
    for (int n = 0; n < 8; n++) begin
      r = $urandom_range(1, 3);
      i_miss_addr = 16'($urandom);
      d_miss_addr = 16'($urandom);
      i_miss = r[0];
      d_miss = r[1];
      s = pick(r[0], r[1]);
      run_fill(s, s ? d_miss_addr : i_miss_addr, 0, 0, 10 + L);
      i_miss = 1'b0;
      d_miss = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs() !== 56'h0) begin
        n_fail++;
        $display("FAIL random_gap n=%0d got=%h want=0", n, obs());
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    salt = 16'($urandom);
    test_reset();
    test_i_only();
    test_tie();
    test_alternate();
    test_rst_mid();
    test_stray();
    test_wrap();
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that sits between the instruction cache, the data cache and the single shared main-memory read port. It arbitrates between I-side and D-side misses and sequences an 8-word block fill from pipelined memory into the granted cache, one word write per returned beat. It then writes the tag and signals completion. It owns the memory read port for the whole fill.

## Interface
- MEM_LATENCY, 4, cycles from a mem_enable issue to the matching mem_data_valid beat (≥1)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_miss  in  1  I-cache miss (level, held until fill completes)
- i_miss_addr  in  16  I-side missing byte address
- d_miss  in  1  D-cache miss (level)
- d_miss_addr  in  16  D-side missing byte address
- mem_enable  out  1  memory read issue strobe
- mem_addr  out  16  memory read address
- mem_data_in  in  16  returned read data
- mem_data_valid  in  1  returned-data beat valid
- fill_addr  out  16  address driven to the granted cache during writes
- fill_data  out  16  word written to the granted cache (= mem_data_in)
- i_data_write / d_data_write  out  1  per-cache data-array write strobe
- i_tag_write / d_tag_write  out  1  per-cache tag-array write strobe
- i_fill_done / d_fill_done  out  1  one-cycle completion pulse
- busy  out  1  state ≠ IDLE; the D-side write path stalls on it

## Operation
- States: IDLE, FILL, TAG, DONE.
- IDLE, arbitration:
  - Exactly one miss high: grant that side.
  - Both high: grant the side not served last. The last_grant register resets to I, so the first tie goes to D.
  - On grant, latch base = miss_addr & 16'hFFF0 and the side, then move to FILL.
  - The miss address is not sampled again until the next IDLE.
- FILL, issue side:
  - issue_cnt runs 0..7.
  - mem_enable = 1 and mem_addr = base | (issue_cnt<<1) each cycle while issue_cnt < 8.
  - Exactly 8 issues, on consecutive cycles.
- FILL, receive side:
  - recv_cnt runs 0..7.
  - Each mem_data_valid asserts the granted side's data_write, with fill_addr = base | (recv_cnt<<1) and fill_data = mem_data_in, then increments recv_cnt.
  - Memory returns beats in order.
  - The 8th beat moves the FSM to TAG.
  - Issue and receive overlap.
- TAG: one cycle; assert the granted side's tag_write with fill_addr = base.
- DONE: pulse the granted side's fill_done, update last_grant, return to IDLE. The requester's miss deasserts here because the tag now matches.
- mem_data_valid outside FILL, and any beat after the 8th, is ignored. No write occurs.
- Write strobes go only to the granted cache. The other side's strobes stay 0.
- Address arithmetic is 16-bit. Word offset bits [3:1] come from the counter and bit 0 is 0. No carry into bits [15:4].

## Timing
- Reset value of every output is 0: mem_enable, mem_addr, fill_addr, fill_data, all write strobes, both done pulses, busy. State resets to IDLE, counters to 0, last_grant to I.
- Let cycle 0 be the IDLE cycle in which the miss is sampled.
  - FILL begins at cycle 1; issues occur at cycles 1..8.
  - Word k is written at cycle 1+k+MEM_LATENCY.
  - TAG occurs at 9+MEM_LATENCY, DONE at 10+MEM_LATENCY, IDLE at 11+MEM_LATENCY.
  - With MEM_LATENCY = 4: TAG at 13, DONE at 14.
- A pending request from the other side is granted in the first IDLE cycle after DONE. There is therefore one idle cycle between back-to-back fills.
- rst mid-fill, on the next edge:
  - Return to IDLE with all outputs 0.
  - Memory beats still in flight are discarded.
  - No tag write occurs, so the cache stays missed and re-requests.
- A miss that drops mid-fill (e.g. a squashed fetch) does not abort the fill; the block still fills and the done pulse still occurs.

## Test plan
- I-only fill, MEM_LATENCY = 4, i_miss_addr = 16'h1236:
  - Required: mem_addr 16'h1230..16'h123E at cycles 1..8.
  - Required: i_data_write at cycles 5..12 with fill_addr 16'h1230..16'h123E carrying memory data.
  - Required: i_tag_write at 13, i_fill_done at 14; d_* strobes stay 0.
- Simultaneous i_miss and d_miss after reset:
  - D is served first and d_fill_done pulses at 14.
  - I is granted at 15 and i_fill_done pulses at 29.
- Repeated ties: grants alternate D, I, D, I across 4 fills.
- rst asserted at cycle 7 of a fill:
  - At cycle 8, all outputs are 0 and busy = 0.
  - Late mem_data_valid beats cause no writes.
  - The still-high miss restarts the fill from offset 0.
- mem_data_valid pulsed while IDLE, and a 9th beat during FILL: no data_write and no counter change.
- Address wrap, miss_addr = 16'hFFFE: issues 16'hFFF0..16'hFFFE with no carry, and the tag write occurs at fill_addr 16'hFFF0.
